// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command queue front-end.
// SPI_CMD_TIMEOUT_EN (see spi_cmd_queue) enables the RUN watchdog.
package spi_cmd_pkg;

   localparam int CMD_ADDR_W = 8;
   localparam int CMD_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RECOVER
   } spi_cmd_state_e;

   typedef struct packed {
      logic                  wr;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] data;
   } spi_cmd_t;

   function automatic spi_cmd_t pack_cmd(
      input logic                  wr,
      input logic [CMD_ADDR_W-1:0] addr,
      input logic [CMD_DATA_W-1:0] data
   );
      spi_cmd_t c;
      c.wr   = wr;
      c.addr = addr;
      c.data = data;
      return c;
   endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; level is a registered count so full/empty
// are plain decodes with no same-cycle pop-to-push path.
module spi_cmd_fifo
   import spi_cmd_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  spi_cmd_t         wdata,
   input  logic             pop,
   output spi_cmd_t         rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   spi_cmd_t         mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) rptr <= rptr + 1'b1;
         if (do_push && !do_pop) level <= level + 1'b1;
         else if (!do_push && do_pop) level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/spi_cmd_queue.sv
// Issues queued host commands one at a time to the SPI memory top level.
// Define SPI_CMD_TIMEOUT_EN to add a RUN watchdog of TIMEOUT_CYC cycles.
module spi_cmd_queue
   import spi_cmd_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int ADDR_W      = CMD_ADDR_W,
   parameter int DATA_W      = CMD_DATA_W,
   parameter int TIMEOUT_CYC = 1023,
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [LVL_W-1:0]  cmd_level,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_wr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              mem_rst,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_done,
   input  logic              mem_err
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("spi_cmd_queue: DEPTH must be a power of two >= 2, TIMEOUT_CYC >= 1");
   end

   spi_cmd_state_e    state;
   spi_cmd_state_e    state_nx;
   spi_cmd_t          push_cmd;
   spi_cmd_t          head;
   logic              full;
   logic              empty;
   logic              pop;

   logic              mem_rst_nx;
   logic              mem_wr_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [DATA_W-1:0] mem_din_nx;
   logic              rsp_valid_nx;
   logic              rsp_wr_nx;
   logic [DATA_W-1:0] rsp_data_nx;
   logic              rsp_err_nx;

`ifdef SPI_CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_cnt_nx;
   logic             tmo_hit;

   // Counter is 0 on the first RUN cycle, so expiry on TIMEOUT_CYC-1
   // puts the response out TIMEOUT_CYC cycles after RUN entry.
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`endif

   assign push_cmd  = pack_cmd(cmd_wr, cmd_addr, cmd_data);
   assign cmd_ready = ~full;

   spi_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .wdata (push_cmd),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (cmd_level)
   );

   always_comb begin
      state_nx     = state;
      pop          = 1'b0;
      mem_rst_nx   = mem_rst;
      mem_wr_nx    = mem_wr;
      mem_addr_nx  = mem_addr;
      mem_din_nx   = mem_din;
      rsp_valid_nx = rsp_valid & ~rsp_ready;
      rsp_wr_nx    = rsp_wr;
      rsp_data_nx  = rsp_data;
      rsp_err_nx   = rsp_err;
`ifdef SPI_CMD_TIMEOUT_EN
      tmo_cnt_nx   = tmo_cnt;
`endif
      case (state)
         IDLE: begin
            mem_rst_nx = 1'b1;
            // One response outstanding at most: wait for the slot to drain.
            if (!empty && !rsp_valid) begin
               pop         = 1'b1;
               mem_wr_nx   = head.wr;
               mem_addr_nx = head.addr;
               mem_din_nx  = head.data;
               mem_rst_nx  = 1'b0;
               state_nx    = RUN;
`ifdef SPI_CMD_TIMEOUT_EN
               tmo_cnt_nx  = '0;
`endif
            end
         end
         RUN: begin
            if (mem_done || mem_err) begin
               rsp_valid_nx = 1'b1;
               rsp_wr_nx    = mem_wr;
               rsp_data_nx  = mem_wr ? '0 : mem_dout;
               rsp_err_nx   = mem_err;
               mem_rst_nx   = 1'b1;
               state_nx     = RECOVER;
            end
`ifdef SPI_CMD_TIMEOUT_EN
            else if (tmo_hit) begin
               rsp_valid_nx = 1'b1;
               rsp_wr_nx    = mem_wr;
               rsp_data_nx  = '0;
               rsp_err_nx   = 1'b1;
               mem_rst_nx   = 1'b1;
               state_nx     = RECOVER;
            end else begin
               tmo_cnt_nx = tmo_cnt + 1'b1;
            end
`endif
         end
         RECOVER: begin
            mem_rst_nx = 1'b1;
            state_nx   = IDLE;
         end
         default: begin
            mem_rst_nx = 1'b1;
            state_nx   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_rst   <= 1'b1;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         rsp_valid <= 1'b0;
         rsp_wr    <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         mem_rst   <= mem_rst_nx;
         mem_wr    <= mem_wr_nx;
         mem_addr  <= mem_addr_nx;
         mem_din   <= mem_din_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_wr    <= rsp_wr_nx;
         rsp_data  <= rsp_data_nx;
         rsp_err   <= rsp_err_nx;
      end
   end

`ifdef SPI_CMD_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt_nx;
   end
`endif

endmodule
